sram_bank_ctrl: RTL and testbench

//  Requester-side controller for the 2-port SRAM bank (32 x 16b, one-hot wordlines).

---
 rtl/sram_bank_pkg.sv | 14 +
 rtl/sram_addr_onehot.sv | 14 +
 rtl/sram_bank_ctrl.sv | 133 +++++++++++++
 tb/tb_sram_bank_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_pkg.sv
// rtl/sram_bank_pkg.sv - shared constants and state encoding for the SRAM bank controller
package sram_bank_pkg;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int NWORDS    = 1 << ADDR_W;
  localparam int SETUP_CYC = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/sram_addr_onehot.sv
// rtl/sram_addr_onehot.sv - combinational binary address to one-hot wordline decoder
module sram_addr_onehot #(
  parameter int AW = sram_bank_pkg::ADDR_W
) (
  input  logic [AW-1:0]      addr_i,
  output logic [(1<<AW)-1:0] onehot_o
);
  import sram_bank_pkg::*;

  always_comb begin
    onehot_o         = '0;
    onehot_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - requester-side sequencer for the 2-port 32x16 SRAM bank
// Registers every array-facing signal so wordlines and enables never glitch.
module sram_bank_ctrl #(
  parameter int ADDR_W    = sram_bank_pkg::ADDR_W,
  parameter int DATA_W    = sram_bank_pkg::DATA_W,
  parameter int SETUP_CYC = sram_bank_pkg::SETUP_CYC
) (
  input  logic                   srclkpos,
  input  logic                   rstneg,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   wr_done,
  output logic [(1<<ADDR_W)-1:0] arr_wordA,
  output logic [(1<<ADDR_W)-1:0] arr_wordB,
  output logic                   arr_ReadEn,
  output logic                   arr_WriteEn,
  output logic [DATA_W-1:0]      arr_in,
  input  logic [DATA_W-1:0]      arr_outA,
  input  logic [DATA_W-1:0]      arr_outB
);
  import sram_bank_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(SETUP_CYC - 1);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [(1<<ADDR_W)-1:0]  word_q;
  logic [(1<<ADDR_W)-1:0]  dec_word;
  logic                    req_ready_q;
  logic                    ren_q;
  logic                    wen_q;
  logic [DATA_W-1:0]       arr_in_q;
  logic                    wr_done_q;
  logic                    rsp_valid_q;
  logic [DATA_W-1:0]       rsp_data_q;
  logic                    rsp_err_q;

  sram_addr_onehot #(.AW(ADDR_W)) u_dec (
    .addr_i   (req_addr),
    .onehot_o (dec_word)
  );

  // req_ready comes up one cycle after reset release so no command is taken mid-reset
  always_ff @(posedge srclkpos or negedge rstneg) begin
    if (!rstneg) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      word_q      <= '0;
      req_ready_q <= 1'b0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      arr_in_q    <= '0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            word_q      <= dec_word;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= ACCESS;
            if (we_q) begin
              wen_q    <= 1'b1;
              arr_in_q <= wdata_q;
            end else begin
              ren_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACCESS: begin
          ren_q    <= 1'b0;
          wen_q    <= 1'b0;
          arr_in_q <= '0;
          word_q   <= '0;
          if (we_q) begin
            wr_done_q   <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            rsp_data_q  <= arr_outA;
            rsp_err_q   <= (arr_outA != arr_outB);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign wr_done     = wr_done_q;
  assign arr_wordA   = word_q;
  assign arr_wordB   = word_q;
  assign arr_ReadEn  = ren_q;
  assign arr_WriteEn = wen_q;
  assign arr_in      = arr_in_q;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - self-checking bench for sram_bank_ctrl with array model and reference memory
module tb_sram_bank_ctrl;
  localparam int SC = 1;

  logic        clk = 1'b0;
  logic        rstneg;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, wr_done;
  logic [15:0] rsp_data;
  logic [31:0] arr_wordA, arr_wordB;
  logic        arr_ReadEn, arr_WriteEn;
  logic [15:0] arr_in, arr_outA, arr_outB;

  logic [15:0] mem [32];
  logic [15:0] ref_mem [32];
  logic        minit = 1'b0;
  logic        fb;
  logic [15:0] fbv;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wd;
    int          hold;
    logic        fb;
    logic [15:0] fbv;
    logic [31:0] exp_w;
    logic [15:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [6];

  sram_bank_ctrl #(.ADDR_W(5), .DATA_W(16), .SETUP_CYC(SC)) dut (
    .srclkpos(clk), .rstneg(rstneg),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .wr_done(wr_done),
    .arr_wordA(arr_wordA), .arr_wordB(arr_wordB),
    .arr_ReadEn(arr_ReadEn), .arr_WriteEn(arr_WriteEn),
    .arr_in(arr_in), .arr_outA(arr_outA), .arr_outB(arr_outB)
  );

  always #5 clk = ~clk;

  function automatic int oh_idx(logic [31:0] w);
    for (int i = 0; i < 32; i++) if (w[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Behavioural SRAM: port data follows the selected word; port B can be overridden
  always @(posedge clk) begin
    if (!minit) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      minit <= 1'b1;
    end else if (arr_WriteEn) begin
      mem[oh_idx(arr_wordA)] <= arr_in;
    end
  end

  always_comb begin
    arr_outA = mem[oh_idx(arr_wordA)];
    arr_outB = fb ? fbv : mem[oh_idx(arr_wordB)];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstneg === 1'b1) begin
      chk("en_mutex", {63'd0, arr_ReadEn & arr_WriteEn}, 64'd0);
      chk("word_b_eq_a", {32'd0, arr_wordB}, {32'd0, arr_wordA});
      if (arr_ReadEn || arr_WriteEn)
        chk("onehot_when_en", $countones(arr_wordA), 64'd1);
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_wordA"}, arr_wordA, 0);
    chk({tag, "_wordB"}, arr_wordB, 0);
    chk({tag, "_ren"}, arr_ReadEn, 0);
    chk({tag, "_wen"}, arr_WriteEn, 0);
    chk({tag, "_arr_in"}, arr_in, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  // Called at a negedge with reset asserted; returns at a negedge with the controller ready
  task automatic rst_release();
    @(posedge clk);
    #1 rstneg = 1'b1;
    @(negedge clk);
    chk("rel_ready_low", req_ready, 0);
    chk("rel_wen", arr_WriteEn, 0);
    chk("rel_wr_done", wr_done, 0);
    @(negedge clk);
    chk("rel_ready_high", req_ready, 1);
    chk("rel_rsp_valid", rsp_valid, 0);
  endtask

  // Entered and left at a negedge with req_ready expected high
  task automatic do_txn(input vec_t v);
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wd;
    fb = v.fb; fbv = v.fbv;
    rsp_ready = (v.hold == 0);
    @(posedge clk);
    #1 req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wd;
    for (int k = 0; k < SC; k++) begin
      @(negedge clk);
      chk("setup_wordA", arr_wordA, v.exp_w);
      chk("setup_en", {arr_ReadEn, arr_WriteEn}, 0);
      chk("setup_arr_in", arr_in, 0);
      chk("setup_ready", req_ready, 0);
      chk("setup_wr_done", wr_done, 0);
      chk("setup_rsp_valid", rsp_valid, 0);
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("acc_wordA", arr_wordA, v.exp_w);
    chk("acc_ren", arr_ReadEn, !v.we);
    chk("acc_wen", arr_WriteEn, v.we);
    chk("acc_arr_in", arr_in, v.we ? v.wd : 16'h0);
    chk("acc_ready", req_ready, 0);
    chk("acc_wr_done", wr_done, 0);
    @(posedge clk);
    @(negedge clk);
    if (v.we) begin
      ref_mem[v.addr] = v.wd;
      chk("wr_done_pulse", wr_done, 1);
      chk("wr_ready_back", req_ready, 1);
      chk("wr_wen_off", arr_WriteEn, 0);
      chk("wr_word_off", arr_wordA, 0);
    end else begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, v.exp_d);
      chk("rsp_err", rsp_err, v.exp_e);
      chk("rsp_word_off", arr_wordA, 0);
      chk("rsp_ren_off", arr_ReadEn, 0);
      chk("rsp_ready_low", req_ready, 0);
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, v.exp_d);
        chk("hold_err", rsp_err, v.exp_e);
        chk("hold_ready_low", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rsp_done_valid", rsp_valid, 0);
      chk("rsp_done_ready", req_ready, 1);
      rsp_ready = 1'b0;
    end
    fb = 1'b0;
  endtask

  initial begin
    vec_t r;
    logic [4:0] a;
    fb = 1'b0; fbv = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

    //      we    addr   wdata      hold fb    fbv        exp_w          exp_d      exp_e
    tbl[0] = '{1'b1, 5'd5,  16'hA5A5, 0, 1'b0, 16'h0000, 32'h0000_0020, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 5'd31, 16'h1234, 0, 1'b0, 16'h0000, 32'h8000_0000, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 5'd31, 16'h0000, 0, 1'b0, 16'h0000, 32'h8000_0000, 16'h1234, 1'b0};
    tbl[3] = '{1'b0, 5'd5,  16'h0000, 4, 1'b0, 16'h0000, 32'h0000_0020, 16'hA5A5, 1'b0};
    tbl[4] = '{1'b1, 5'd0,  16'h00FF, 0, 1'b0, 16'h0000, 32'h0000_0001, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 5'd0,  16'h0000, 1, 1'b1, 16'h0F0F, 32'h0000_0001, 16'h00FF, 1'b1};

    rstneg = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd3; req_wdata = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("rst");
    end
    @(posedge clk);
    #1 rstneg = 1'b1;
    @(negedge clk);
    chk_quiet("rel");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);
    chk("rel_no_access_wordA", arr_wordA, 0);
    chk("rel_mem3_intact", mem[3], ref_mem[3]);

    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // Reset during SETUP of a write: the write must vanish
    r = '{1'b0, 5'd7, 16'h0, 0, 1'b0, 16'h0, 32'h80, 16'h0, 1'b0};
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 16'hDEAD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rstneg = 1'b0;
    #1 chk("midsetup_word_clr", arr_wordA, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midsetup_wen", arr_WriteEn, 0);
      chk("midsetup_wr_done", wr_done, 0);
    end
    rst_release();
    chk("midsetup_mem7", mem[7], ref_mem[7]);
    r.exp_d = ref_mem[7];
    do_txn(r);

    // Reset during ACCESS of a read: ReadEn must drop without waiting for a clock
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (SC) @(posedge clk);
    #2 chk("midacc_ren_on", arr_ReadEn, 1);
    rstneg = 1'b0;
    #1 chk("midacc_ren_async", arr_ReadEn, 0);
    chk("midacc_word_async", arr_wordA, 0);
    @(negedge clk);
    rst_release();
    chk("midacc_no_rsp", rsp_valid, 0);

    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom_range(0, 31));
      r.we    = ($urandom_range(0, 1) == 1);
      r.addr  = a;
      r.wd    = 16'($urandom);
      r.hold  = $urandom_range(0, 3);
      r.fb    = !r.we && ($urandom_range(0, 5) == 0);
      r.exp_w = 32'h1 << a;
      r.exp_d = ref_mem[a];
      r.fbv   = ref_mem[a] ^ (16'h1 << $urandom_range(0, 15));
      r.exp_e = r.fb;
      do_txn(r);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
